// File: rtl/detect_pkg.sv
// Shared types and defaults for the red-point detector frame sequencer.
package detect_pkg;

    localparam int POS_W_DEF = 13;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        SKIP,
        ARMED,
        REPORT
    } state_e;

endpackage

// File: rtl/detect_ctrl_if.sv
// Result channel from the frame sequencer to the tracking/display consumer.
interface detect_ctrl_if #(
    parameter int POS_W = detect_pkg::POS_W_DEF
) ();

    logic             o_valid;
    logic             i_ready;
    logic             o_hit;
    logic [POS_W-1:0] o_X_pos;
    logic [POS_W-1:0] o_Y_pos;

    modport master (output o_valid, o_hit, o_X_pos, o_Y_pos, input i_ready);
    modport slave  (input o_valid, o_hit, o_X_pos, o_Y_pos, output i_ready);

endinterface

// File: rtl/frame_edge.sv
// Registers the CCD frame-valid level and derives its rise/fall strobes.
module frame_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_valid,
    output logic o_rise,
    output logic o_fall
);

    logic fv_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fv_q <= 1'b0;
        else      fv_q <= i_frame_valid;
    end

    assign o_rise = i_frame_valid & ~fv_q;
    assign o_fall = ~i_frame_valid & fv_q;

endmodule

// File: rtl/detect_ctrl.sv
// Frame-level sequencer: arms the detector on selected frames, captures the first
// hit and reports one hit/miss result per armed frame, tracking consecutive misses.
module detect_ctrl
    import detect_pkg::*;
#(
    parameter int POS_W      = POS_W_DEF,
    parameter int FRAME_SKIP = 0,
    parameter int MISS_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_frame_valid,
    output logic             o_new_frame,
    output logic             o_end_frame,
    input  logic             i_detect,
    input  logic [POS_W-1:0] i_X_pos,
    input  logic [POS_W-1:0] i_Y_pos,
    detect_ctrl_if.master    res,
    output logic             o_lost,
    output logic [15:0]      o_frame_cnt
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int SKIP_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam logic [MISS_W-1:0] MISS_MAX    = MISS_W'(MISS_LIMIT);
    localparam logic [SKIP_W-1:0] SKIP_RELOAD = SKIP_W'(FRAME_SKIP);

    logic rise, fall;

    frame_edge u_frame_edge (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (i_frame_valid),
        .o_rise        (rise),
        .o_fall        (fall)
    );

    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              latch_q, latch_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic              nf_q, nf_d, ef_q, ef_d, valid_q, valid_d, hit_q, hit_d, lost_q, lost_d;
    logic [POS_W-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic [15:0]       cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        miss_d  = miss_q;
        latch_d = latch_q;
        x_d     = x_q;
        y_d     = y_q;
        nf_d    = 1'b0;
        ef_d    = 1'b0;
        valid_d = valid_q;
        hit_d   = hit_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: if (i_enable) state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (rise) begin
                    if (skip_q == '0) begin
                        nf_d    = 1'b1;
                        latch_d = 1'b0;
                        state_d = ARMED;
                    end else begin
                        skip_d  = skip_q - SKIP_W'(1);
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (!i_enable) state_d = IDLE;
                else if (fall) state_d = WAIT_SOF;
            end
            ARMED: begin
                // A detect coincident with the falling edge still belongs to this frame.
                if (i_detect && !latch_q) begin
                    latch_d = 1'b1;
                    x_d     = i_X_pos;
                    y_d     = i_Y_pos;
                end
                if (fall) begin
                    ef_d    = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    valid_d = 1'b1;
                    hit_d   = latch_d;
                    ox_d    = latch_d ? x_d : '0;
                    oy_d    = latch_d ? y_d : '0;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (res.i_ready) begin
                    miss_d  = hit_q ? '0 : ((miss_q == MISS_MAX) ? MISS_MAX : miss_q + MISS_W'(1));
                    skip_d  = SKIP_RELOAD;
                    valid_d = 1'b0;
                    hit_d   = 1'b0;
                    ox_d    = '0;
                    oy_d    = '0;
                    state_d = i_enable ? WAIT_SOF : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        lost_d = (miss_d == MISS_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            skip_q  <= '0;
            miss_q  <= '0;
            latch_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            nf_q    <= 1'b0;
            ef_q    <= 1'b0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            miss_q  <= miss_d;
            latch_q <= latch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            nf_q    <= nf_d;
            ef_q    <= ef_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            lost_q  <= lost_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_new_frame = nf_q;
    assign o_end_frame = ef_q;
    assign o_lost      = lost_q;
    assign o_frame_cnt = cnt_q;
    assign res.o_valid = valid_q;
    assign res.o_hit   = hit_q;
    assign res.o_X_pos = ox_q;
    assign res.o_Y_pos = oy_q;

endmodule

// File: tb/tb_detect_ctrl.sv
// Scoreboard bench for detect_ctrl: two instances (no skip / skip of 2) share one
// randomized CCD stream and are checked against a frame-level reference model.
module tb_detect_ctrl;

    localparam int PW = 13;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, fv = 1'b0, det = 1'b0, rdy = 1'b0;
    logic [PW-1:0] xp = '0, yp = '0;

    logic [1:0] nf, ef, lost, val, hit;
    logic [PW-1:0] xo [2];
    logic [PW-1:0] yo [2];
    logic [15:0] fcnt [2];

    detect_ctrl_if #(.POS_W(PW)) if0 ();
    detect_ctrl_if #(.POS_W(PW)) if1 ();
    assign if0.i_ready = rdy;
    assign if1.i_ready = rdy;
    assign val   = {if1.o_valid, if0.o_valid};
    assign hit   = {if1.o_hit, if0.o_hit};
    assign xo[0] = if0.o_X_pos;
    assign xo[1] = if1.o_X_pos;
    assign yo[0] = if0.o_Y_pos;
    assign yo[1] = if1.o_Y_pos;

    detect_ctrl #(.POS_W(PW), .FRAME_SKIP(0), .MISS_LIMIT(ML)) dut0 (
        .clk(clk), .rst(rst), .i_enable(en), .i_frame_valid(fv),
        .o_new_frame(nf[0]), .o_end_frame(ef[0]), .i_detect(det),
        .i_X_pos(xp), .i_Y_pos(yp), .res(if0), .o_lost(lost[0]), .o_frame_cnt(fcnt[0]));

    detect_ctrl #(.POS_W(PW), .FRAME_SKIP(2), .MISS_LIMIT(ML)) dut1 (
        .clk(clk), .rst(rst), .i_enable(en), .i_frame_valid(fv),
        .o_new_frame(nf[1]), .o_end_frame(ef[1]), .i_detect(det),
        .i_X_pos(xp), .i_Y_pos(yp), .res(if1), .o_lost(lost[1]), .o_frame_cnt(fcnt[1]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level phases) ----------------
    typedef struct packed {
        logic          hit;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    bit            waiting [2];
    bit            skipping[2];
    bit            armed   [2];
    bit            pend    [2];
    bit            found   [2];
    logic [PW-1:0] fx      [2];
    logic [PW-1:0] fy      [2];
    int            skip_left[2];
    int            misses  [2];
    int            frames  [2];
    bit            e_nf[2], e_ef[2], e_val[2], e_lost[2];
    bit            fv_prev;

    function automatic int skip_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        fv_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            waiting[k] = 0; skipping[k] = 0; armed[k] = 0; pend[k] = 0; found[k] = 0;
            fx[k] = '0; fy[k] = '0; skip_left[k] = 0; misses[k] = 0; frames[k] = 0;
            e_nf[k] = 0; e_ef[k] = 0; e_val[k] = 0; e_lost[k] = 0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic model_step();
        bit rise, fall;
        exp_t e;
        rise = fv && !fv_prev;
        fall = !fv && fv_prev;
        fv_prev = fv;
        for (int k = 0; k < 2; k++) begin
            e_nf[k] = 0;
            e_ef[k] = 0;
            if (pend[k]) begin
                if (rdy) begin
                    misses[k]    = found[k] ? 0 : ((misses[k] + 1 > ML) ? ML : misses[k] + 1);
                    skip_left[k] = skip_of(k);
                    pend[k]      = 0;
                    e_val[k]     = 0;
                    waiting[k]   = en;
                end
            end else if (armed[k]) begin
                if (det && !found[k]) begin
                    found[k] = 1; fx[k] = xp; fy[k] = yp;
                end
                if (fall) begin
                    frames[k]++;
                    e.hit = found[k];
                    e.x   = found[k] ? fx[k] : '0;
                    e.y   = found[k] ? fy[k] : '0;
                    e.cnt = 16'(frames[k]);
                    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
                    e_ef[k] = 1; armed[k] = 0; pend[k] = 1; e_val[k] = 1;
                end
            end else if (skipping[k]) begin
                if (!en) skipping[k] = 0;
                else if (fall) begin skipping[k] = 0; waiting[k] = 1; end
            end else if (waiting[k]) begin
                if (!en) waiting[k] = 0;
                else if (rise) begin
                    waiting[k] = 0;
                    if (skip_left[k] == 0) begin e_nf[k] = 1; found[k] = 0; armed[k] = 1; end
                    else begin skip_left[k]--; skipping[k] = 1; end
                end
            end else if (en) begin
                waiting[k] = 1;
            end
            e_lost[k] = (misses[k] == ML);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else      model_step();
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        #2;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("new_frame[%0d]", k), 64'(nf[k]), 64'(e_nf[k]));
                check($sformatf("end_frame[%0d]", k), 64'(ef[k]), 64'(e_ef[k]));
                check($sformatf("valid[%0d]", k), 64'(val[k]), 64'(e_val[k]));
                check($sformatf("lost[%0d]", k), 64'(lost[k]), 64'(e_lost[k]));
                if (val[k]) begin
                    if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL result[%0d]: got unexpected valid, expected no result at %0t", k, $time);
                    end else begin
                        exp_t e;
                        e = (k == 0) ? sb0[0] : sb1[0];
                        check($sformatf("result[%0d]", k), 64'({hit[k], xo[k], yo[k], fcnt[k]}), 64'(e));
                        if (rdy) begin
                            if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int stall_left = 0;
    bit rdy_rand   = 0;

    task automatic drive_ready();
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else if (rdy_rand)  rdy = ($urandom_range(0, 3) != 0);
        else                rdy = 1'b1;
    endtask

    task automatic cyc(input bit f, input bit d);
        @(negedge clk);
        fv  = f;
        det = d;
        if (d) begin xp = PW'($urandom); yp = PW'($urandom); end
        drive_ready();
    endtask

    task automatic cyc_at(input bit f, input int x, input int y);
        @(negedge clk);
        fv = f; det = 1'b1; xp = PW'(x); yp = PW'(y);
        drive_ready();
    endtask

    task automatic plain_frame(input int len, input int gap);
        for (int i = 0; i < len; i++) cyc(1, 0);
        for (int i = 0; i < gap; i++) cyc(0, 0);
    endtask

    task automatic rand_frame();
        int len, gap, p;
        len = $urandom_range(6, 40);
        gap = $urandom_range(2, 12);
        p   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
        for (int i = 0; i < len; i++) cyc(1, $urandom_range(0, 99) < p);
        en = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < gap; i++) cyc(0, $urandom_range(0, 99) < p);
        en = 1'b1;
    endtask

    task automatic reset_outputs_zero(input string tag);
        for (int k = 0; k < 2; k++)
            check($sformatf("%s[%0d]", tag, k),
                  64'({nf[k], ef[k], val[k], hit[k], lost[k], xo[k], yo[k], fcnt[k]}), 64'd0);
    endtask

    initial begin
        model_reset();
        #2;
        reset_outputs_zero("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        rdy = 1'b1;
        repeat (5) cyc(0, 0);

        // Long frame with a single hit.
        for (int i = 0; i < 1000; i++) begin
            if (i == 300) cyc_at(1, 100, 50); else cyc(1, 0);
        end
        repeat (10) cyc(0, 0);

        // Several detects, including one on the falling edge: first one wins.
        for (int i = 0; i < 40; i++) begin
            if (i == 10)      cyc_at(1, 100, 50);
            else if (i == 20) cyc_at(1, 200, 60);
            else              cyc(1, 0);
        end
        cyc_at(0, 300, 70);
        repeat (8) cyc(0, 0);

        // Detect only on the falling edge still counts as a hit.
        for (int i = 0; i < 20; i++) cyc(1, 0);
        cyc_at(0, 7, 9);
        repeat (8) cyc(0, 0);

        // Consecutive misses up to and past the limit, then recovery.
        repeat (6) plain_frame(20, 6);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) cyc_at(1, 11, 22); else cyc(1, 0);
        end
        repeat (6) cyc(0, 0);

        // Consumer stalls over ~1.5 frames; the overlapping frame is not armed.
        plain_frame(40, 10);
        stall_left = 75;
        plain_frame(40, 10);
        plain_frame(40, 10);
        plain_frame(40, 10);

        // Randomized traffic with random back-pressure and enable drops.
        rdy_rand = 1;
        repeat (200) rand_frame();

        // Asynchronous reset in the middle of an armed frame.
        rdy_rand = 0;
        repeat (15) cyc(0, 0);
        repeat (6) cyc(1, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        reset_outputs_zero("async_reset");
        model_reset();
        repeat (2) cyc(1, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) cyc(1, 0);
        repeat (6) cyc(0, 0);
        rdy_rand = 1;
        repeat (30) rand_frame();
        repeat (80) cyc(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detect_ctrl.md
Name: detect_ctrl

Overview:
Frame-level sequencer for the red-point detector.
- Turns the CCD frame-valid level into the detector's new_frame/end_frame strobes.
- Arms detection only on selected frames and captures the first detect pulse with its position.
- Reports one hit/miss result per armed frame over a valid/ready handshake and tracks target loss across consecutive misses.
- Sits between CCD capture and the downstream tracking/display logic.

Parameters:
POS_W, 13, width of X/Y position buses
FRAME_SKIP, 0, number of frames ignored between armed frames
MISS_LIMIT, 4, consecutive reported misses that assert o_lost (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
i_enable  in  1  run request (level)
i_frame_valid  in  1  CCD frame-valid level, synchronous to clk
o_new_frame  out  1  one-cycle pulse to detector at armed frame start
o_end_frame  out  1  one-cycle pulse to detector at armed frame end
i_detect  in  1  detector hit pulse
i_X_pos  in  POS_W  detector X position
i_Y_pos  in  POS_W  detector Y position
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_hit  out  1  1 = red point found, 0 = miss
o_X_pos  out  POS_W  captured X (0 on miss)
o_Y_pos  out  POS_W  captured Y (0 on miss)
o_lost  out  1  consecutive misses >= MISS_LIMIT
o_frame_cnt  out  16  completed armed frames, wraps

Behaviour:
- Reset (asynchronous, active-low) clears everything immediately: all outputs 0, state IDLE, skip_cnt=0 so the first frame is armed, miss_cnt=0, hit latch=0, fv_q=0.
- Edge detect: fv_q is the registered i_frame_valid. rise = i_frame_valid & ~fv_q; fall = ~i_frame_valid & fv_q.
- All outputs are registered. A strobe decided at clock edge N is high for exactly cycle N..N+1.
- IDLE: when i_enable=1, go to WAIT_SOF.
- WAIT_SOF:
  - If i_enable=0, go to IDLE.
  - On rise with skip_cnt==0: pulse o_new_frame, clear hit latch, go to ARMED.
  - On rise with skip_cnt>0: decrement skip_cnt, go to SKIP.
  - Entering mid-frame gives no rise, so that frame is never armed.
- SKIP:
  - If i_enable=0, go to IDLE.
  - On fall, go to WAIT_SOF.
- ARMED:
  - First i_detect with hit latch=0: latch i_X_pos/i_Y_pos, set hit latch. Later detects in the frame are ignored.
  - On fall: pulse o_end_frame, o_frame_cnt+1 (wraps 16'hFFFF to 0), go to REPORT.
  - i_detect in the same cycle as fall is still captured.
  - i_enable=0 here does not abort; the frame completes.
- REPORT:
  - o_valid=1. o_hit = hit latch. Positions = latched values on a hit, 0 on a miss.
  - Outputs are held stable until i_ready.
  - On o_valid & i_ready:
    - hit: miss_cnt <= 0.
    - miss: miss_cnt <= min(miss_cnt+1, MISS_LIMIT).
    - Reload skip_cnt = FRAME_SKIP, drop o_valid next cycle.
    - Go to WAIT_SOF if i_enable, else IDLE.
  - Frames that start while in REPORT are not armed and do not decrement skip_cnt.
- o_lost: registered, equals (miss_cnt == MISS_LIMIT). Updates the cycle after the handshake.
- miss_cnt width: $clog2(MISS_LIMIT+1).
- o_new_frame and o_end_frame never assert in the same cycle. Neither asserts outside an armed frame.
- Reset asserted mid-frame aborts with no report. After release, arming resumes at the next rise.

Decomposition:
- detect_pkg: state enum {IDLE, WAIT_SOF, SKIP, ARMED, REPORT} and POS_W default constant.
- One sub-module, frame_edge: the fv_q register plus rise/fall outputs, same clk/rst.

Test Plan:
1. FRAME_SKIP=0, i_ready=1, frame of 1000 cycles with one detect at (100,50) -> 1 o_new_frame, 1 o_end_frame, report o_hit=1 X=100 Y=50, o_frame_cnt=1.
2. Detects at (100,50) then (200,60) in one frame, plus a detect coincident with fall -> report (100,50).
3. MISS_LIMIT=4, four frames with no detect -> four reports hit=0, X=Y=0; o_lost=1 after the 4th handshake; a 5th frame with a hit -> o_lost=0.
4. FRAME_SKIP=2, six frames -> o_new_frame only on frames 1 and 4; o_frame_cnt=2.
5. i_ready low for 1.5 frames after a report -> outputs held stable; the overlapping frame gets no o_new_frame; after i_ready, the next full frame is armed.
6. rst low mid-ARMED, asynchronous to clk -> all outputs 0 before the next edge; after release with i_enable=1 and frame_valid already high -> no arming until the next rise.
